// File: rtl/mem_wait_ctrl_if.sv
// Bundles the core-side request/response signals and the RAM/MIOBUS-side
// signals of the data-side bus sequencer.
// master: the core plus memory environment. slave: the sequencer.
interface mem_wait_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              cpu_mio;
    logic              cpu_wr;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              bus_err;

    modport master (
        output cpu_mio, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_ready, busy, mem_addr, mem_we, mem_wdata, bus_err
    );

    modport slave (
        input  cpu_mio, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, cpu_ready, busy, mem_addr, mem_we, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_wait_ctrl.sv
// Data-side bus sequencer. It turns the core's one-cycle load/store request
// into a held, wait-stated RAM/MIOBUS transaction and returns a one-cycle
// cpu_ready pulse. Misaligned or unanswered accesses end with an error word
// and a sticky bus_err, so a missing target can never stall the core forever.
module mem_wait_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    mem_wait_ctrl_if.slave bus
);
    localparam logic [31:0] ERR_WORD = 32'hAA55_AA55;
    localparam logic [3:0]  TO_LAST  = 4'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              wr_hold;
    logic [ADDR_W-1:0] addr_hold;
    logic [31:0]       wdata_hold;
    logic [31:0]       rdata_hold;
    logic              we;
    logic              ready;
    logic              active;
    logic              err;

    logic              aligned;
    logic              finish_ok;
    logic              unused_addr_bits;

    // Word alignment of the incoming byte address.
    assign aligned = (bus.cpu_addr[1:0] == 2'b00);

    // A store finishes on the first acknowledged cycle. A load additionally
    // waits until at least RD_LAT ACCESS cycles have elapsed
    // (wait_cnt + 1 >= RD_LAT, written without a constant-true compare).
    assign finish_ok = bus.mem_ready &&
                       (wr_hold || ((5'(wait_cnt) + 5'd1) >= 5'(RD_LAT)));

    // Byte address bits above the RAM window are intentionally ignored.
    assign unused_addr_bits = ^bus.cpu_addr[31:ADDR_W+2];

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            wr_hold    <= 1'b0;
            addr_hold  <= '0;
            wdata_hold <= 32'd0;
            rdata_hold <= 32'd0;
            we         <= 1'b0;
            ready      <= 1'b0;
            active     <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_mio) begin
                        wr_hold    <= bus.cpu_wr;
                        addr_hold  <= bus.cpu_addr[ADDR_W+1:2];
                        wdata_hold <= bus.cpu_wdata;
                        wait_cnt   <= 4'd0;
                        active     <= 1'b1;
                        if (aligned) begin
                            state <= ACCESS;
                            we    <= bus.cpu_wr;
                        end else begin
                            // Misaligned: never touch memory, answer with the error word.
                            state      <= DONE;
                            ready      <= 1'b1;
                            err        <= 1'b1;
                            rdata_hold <= ERR_WORD;
                        end
                    end
                end
                ACCESS: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if (finish_ok) begin
                        state <= DONE;
                        ready <= 1'b1;
                        we    <= 1'b0;
                        if (!wr_hold) begin
                            rdata_hold <= bus.mem_rdata;
                        end
                    end else if (wait_cnt == TO_LAST) begin
                        // Target never answered: abort so the core cannot hang.
                        state      <= DONE;
                        ready      <= 1'b1;
                        we         <= 1'b0;
                        err        <= 1'b1;
                        rdata_hold <= ERR_WORD;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    ready  <= 1'b0;
                    active <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    ready  <= 1'b0;
                    active <= 1'b0;
                    we     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_rdata = rdata_hold;
    assign bus.cpu_ready = ready;
    assign bus.busy      = active;
    assign bus.mem_addr  = addr_hold;
    assign bus.mem_we    = we;
    assign bus.mem_wdata = wdata_hold;
    assign bus.bus_err   = err;
endmodule
